// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared MMIO addresses, transmitter state encoding and status layout
package mmio_pkg;

  // Default memory-mapped addresses, shared with future MMIO blocks
  localparam logic [14:0] TXDATA_ADDR_DEFAULT = 15'h6001;
  localparam logic [14:0] STATUS_ADDR_DEFAULT = 15'h6002;

  // Serial transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Status word bit positions
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_EMPTY     = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - small byte FIFO feeding the serial transmitter
module uart_tx_fifo import mmio_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written only, never reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - Hack memory-bus mapped 8N1 serial transmitter with status word
module mmio_uart_tx import mmio_pkg::*; #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [14:0] TXDATA_ADDR  = TXDATA_ADDR_DEFAULT,
  parameter logic [14:0] STATUS_ADDR  = STATUS_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] rd_data,
  output logic        rd_hit,
  output logic        tx,
  output logic        busy
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          overflow;

  logic          push_req;
  logic          clr_req;
  logic          pop;
  logic          bit_done;
  logic          ovf_set;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   status;

  // Only the low byte of a CPU write is transmitted
  logic          unused_outm_hi;
  assign unused_outm_hi = ^outM[15:8];

  assign push_req = writeM && (addressM == TXDATA_ADDR);
  assign clr_req  = writeM && (addressM == STATUS_ADDR);
  assign bit_done = (baud_cnt == BAUD_LAST);
  assign ovf_set  = push_req && fifo_full && !pop;

  // Pop when idle with data waiting, or at the end of a stop bit to chain frames gap-free
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      STOP:    pop = bit_done && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (outM[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow flag; a clear write takes priority over a simultaneous drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clr_req) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT long
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            state   <= START;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_dout;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Busy is a registered view of activity, so it lags the FSM by one clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      busy <= (state != IDLE) || !fifo_empty;
    end
  end

  // Status word assembly
  always_comb begin
    status                            = '0;
    status[ST_BUSY]                   = busy;
    status[ST_FULL]                   = fifo_full;
    status[ST_OVERFLOW]               = overflow;
    status[ST_EMPTY]                  = fifo_empty;
    status[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count);
  end

  // Read-path decode merged into the CPU's inM mux
  always_comb begin
    rd_hit  = (addressM == TXDATA_ADDR) || (addressM == STATUS_ADDR);
    rd_data = (addressM == STATUS_ADDR) ? status : 16'h0000;
  end

endmodule
